// File: rtl/mem_access_ctrl.sv
// Load/store controller for the MEM stage: alignment check, byte-lane
// steering, wait-state tolerant memory handshake and load extension.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_sz,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        exc_o,
    output logic [1:0]  exc_code_o,
    output logic [31:0] bad_addr_o,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [8:0] LIMIT = 9'(TIMEOUT_CYCLES);

    state_t      state;
    logic [7:0]  cnt;
    logic [8:0]  cnt_nxt;
    logic [31:0] r_addr;
    logic        r_byte;
    logic        r_half;
    logic        r_sign;
    logic        r_we;

    logic        is_byte;
    logic        is_half;
    logic        aligned;
    logic        accept;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign is_byte = (req_sz == 2'b00);
    assign is_half = (req_sz == 2'b01);
    assign aligned = is_byte
                   | (is_half & ~req_addr[0])
                   | (~is_byte & ~is_half & (req_addr[1:0] == 2'b00));

    // The done/exc guard keeps the request being retired from re-entering.
    assign accept  = (state == IDLE) & req_valid & ~done_o & ~exc_o;
    assign stall_o = (state == ACCESS) | (accept & aligned);
    assign cnt_nxt = {1'b0, cnt} + 9'd1;

    always_comb begin
        lane_wdata = req_wdata;
        lane_be    = 4'b1111;
        unique case (1'b1)
            is_byte: begin
                lane_wdata = {4{req_wdata[7:0]}};
                lane_be    = 4'b0001 << req_addr[1:0];
            end
            is_half: begin
                lane_wdata = {2{req_wdata[15:0]}};
                lane_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[7:0];
        unique case (r_addr[1:0])
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_ext  = mem_rdata;
        unique case (1'b1)
            r_byte:  ld_ext = {{24{r_sign & ld_byte[7]}}, ld_byte};
            r_half:  ld_ext = {{16{r_sign & ld_half[15]}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            r_addr      <= 32'd0;
            r_byte      <= 1'b0;
            r_half      <= 1'b0;
            r_sign      <= 1'b0;
            r_we        <= 1'b0;
            done_o      <= 1'b0;
            load_data_o <= 32'd0;
            exc_o       <= 1'b0;
            exc_code_o  <= 2'b00;
            bad_addr_o  <= 32'd0;
            mem_address <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_byte_en <= 4'd0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
        end else begin
            done_o      <= 1'b0;
            load_data_o <= 32'd0;
            exc_o       <= 1'b0;
            exc_code_o  <= 2'b00;
            bad_addr_o  <= 32'd0;
            unique case (state)
                IDLE: begin
                    if (accept && aligned) begin
                        state       <= ACCESS;
                        cnt         <= 8'd0;
                        r_addr      <= req_addr;
                        r_byte      <= is_byte;
                        r_half      <= is_half;
                        r_sign      <= req_sign;
                        r_we        <= req_we;
                        mem_address <= {req_addr[31:2], 2'b00};
                        mem_wdata   <= lane_wdata;
                        mem_byte_en <= lane_be;
                        mem_rd      <= ~req_we;
                        mem_wr      <= req_we;
                    end else if (accept) begin
                        exc_o      <= 1'b1;
                        exc_code_o <= {1'b0, req_we};
                        bad_addr_o <= req_addr;
                    end
                end
                ACCESS: begin
                    // A ready in the limit cycle still wins over the timeout.
                    if (mem_ready || cnt_nxt >= LIMIT) begin
                        state       <= IDLE;
                        cnt         <= 8'd0;
                        mem_address <= 32'd0;
                        mem_wdata   <= 32'd0;
                        mem_byte_en <= 4'd0;
                        mem_rd      <= 1'b0;
                        mem_wr      <= 1'b0;
                        if (mem_ready) begin
                            done_o      <= 1'b1;
                            load_data_o <= r_we ? 32'd0 : ld_ext;
                        end else begin
                            exc_o      <= 1'b1;
                            exc_code_o <= 2'b10;
                            bad_addr_o <= r_addr;
                        end
                    end else begin
                        cnt <= cnt_nxt[7:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: driver/memory responder pushes
// expected responses, a monitor pops them on done/exc pulses.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_sz;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall_o;
    logic        done_o;
    logic [31:0] load_data_o;
    logic        exc_o;
    logic [1:0]  exc_code_o;
    logic [31:0] bad_addr_o;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_we(req_we),
        .req_sz(req_sz),
        .req_sign(req_sign),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .stall_o(stall_o),
        .done_o(done_o),
        .load_data_o(load_data_o),
        .exc_o(exc_o),
        .exc_code_o(exc_code_o),
        .bad_addr_o(bad_addr_o),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    typedef struct {
        bit          is_exc;
        logic [1:0]  code;
        logic [31:0] bad;
        logic [31:0] ld;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz,
                                            input logic [31:0] addr);
        int n = nbytes(sz);
        int off = int'(addr % 4);
        logic [3:0] be = 4'd0;
        for (int i = 0; i < n; i++) be[off + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz,
                                                input logic [31:0] d);
        int n = nbytes(sz);
        logic [31:0] o = 32'd0;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = d[8*(i % n) +: 8];
        return o;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz,
                                               input bit sign,
                                               input logic [31:0] addr,
                                               input logic [31:0] rd);
        int n = nbytes(sz);
        longint v;
        if (n == 4) return rd;
        v = (longint'(rd) >> (8 * (addr % 4))) & ((64'sd1 << (8 * n)) - 1);
        if (sign && ((v >> (8 * n - 1)) & 1) == 1) v = v - (64'sd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic do_txn(input bit we, input logic [1:0] sz, input bit sign,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits);
        int   n = nbytes(sz);
        bit   al = ((addr % n) == 0);
        int   strobes;
        exp_t e;
        e.is_exc = !al || (waits >= TO);
        e.code   = !al ? {1'b0, we} : 2'b10;
        e.bad    = addr;
        e.ld     = (e.is_exc || we) ? 32'd0 : model_load(sz, sign, addr, rd);
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_sz    = sz;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wd;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        #1 check("stall_accept", stall_o, al);
        if (!al) begin
            @(negedge clk);
            check("misalign_nostrobe", {mem_rd, mem_wr}, 0);
            check("misalign_stall", stall_o, 0);
            check("misalign_exc_timing", exc_o, 1);
        end else begin
            strobes = (waits >= TO) ? TO : waits + 1;
            for (int c = 0; c < strobes; c++) begin
                @(negedge clk);
                check("strobe_rd", mem_rd, !we);
                check("strobe_wr", mem_wr, we);
                check("strobe_addr", mem_address, {addr[31:2], 2'b00});
                check("strobe_be", mem_byte_en, model_be(sz, addr));
                if (we) check("strobe_wdata", mem_wdata, model_wdata(sz, wd));
                check("strobe_stall", stall_o, 1);
                mem_ready = (c == waits);
                mem_rdata = (c == waits) ? rd : $urandom;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            check("end_strobes", {mem_rd, mem_wr}, 0);
            check("end_stall", stall_o, 0);
            check("end_timing", {done_o, exc_o}, (waits >= TO) ? 2'b01 : 2'b10);
        end
        // Hold the request through the retire cycle to exercise the guard.
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("no_reaccept", {mem_rd, mem_wr, exc_o, done_o}, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_o || exc_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: done=%b exc=%b with empty queue", done_o, exc_o);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_exc", exc_o, e.is_exc);
                    check("resp_done", done_o, !e.is_exc);
                    check("resp_load_data", load_data_o, e.ld);
                    if (e.is_exc) begin
                        check("resp_exc_code", exc_code_o, e.code);
                        check("resp_bad_addr", bad_addr_o, e.bad);
                    end
                end
            end else if (rst_n) begin
                check("idle_load_data", load_data_o, 0);
            end
        end
    end

    initial begin : driver
        logic [1:0]  sz;
        logic [31:0] a;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_sz    = 2'b00;
        req_sign  = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        mem_rdata = 32'd0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {stall_o, done_o, exc_o, mem_rd, mem_wr, mem_byte_en}, 0);
        check("reset_addr", mem_address, 0);
        check("reset_data", mem_wdata | load_data_o | bad_addr_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(1, 2'd0, 0, 32'h0000_0013, 32'h0000_00A5, 32'h0, 0);
        do_txn(0, 2'd0, 1, 32'h0000_0021, 32'h0, 32'h1234_80FF, 0);
        do_txn(0, 2'd0, 0, 32'h0000_0021, 32'h0, 32'h1234_80FF, 0);
        do_txn(0, 2'd1, 0, 32'h0000_0042, 32'h0, 32'hBEEF_0000, 3);
        do_txn(1, 2'd2, 0, 32'h0000_0102, 32'h1111_2222, 32'h0, 0);
        do_txn(0, 2'd1, 1, 32'h0000_0043, 32'h0, 32'h0, 0);
        do_txn(0, 2'd2, 0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 10);
        do_txn(0, 2'd2, 1, 32'h0000_0084, 32'h0, 32'h8765_4321, 1);
        do_txn(1, 2'd1, 0, 32'h0000_0046, 32'h0000_9ABC, 32'h0, 2);

        // Reset lands in the second wait cycle of a word store.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_sz    = 2'd2;
        req_sign  = 1'b0;
        req_addr  = 32'h0000_0200;
        req_wdata = 32'hDEAD_BEEF;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("midrst_ctrl", {stall_o, done_o, exc_o, mem_rd, mem_wr, mem_byte_en}, 0);
        check("midrst_addr", mem_address, 0);
        check("midrst_data", mem_wdata | load_data_o | bad_addr_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        do_txn(1, 2'd2, 0, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz)) - 32'd1);
            do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   a, $urandom, $urandom, $urandom_range(0, 5));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store controller in the MEM pipeline stage, directly upstream of the data memory.
- Takes one load or store request at a time from the EX/MEM register and checks alignment.
- Drives a word-addressed memory port with byte enables, waits for memory acknowledge (supports wait states), then returns aligned, sign- or zero-extended load data.
- Raises a pipeline stall while busy, and flags misalignment or bus timeout as exceptions.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_ready before bus error; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present; held stable by pipeline until done_o or exc_o
- req_we  input  1  1 = store, 0 = load
- req_sz  input  2  access size: 00 byte, 01 half, 10 word; 11 treated as word
- req_sign  input  1  load sign-extend (1) or zero-extend (0); ignored for word and store
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- stall_o  output  1  pipeline hold request
- done_o  output  1  one-cycle pulse: access completed
- load_data_o  output  32  extended load result, valid while done_o=1 for loads
- exc_o  output  1  one-cycle pulse: exception, no memory access committed
- exc_code_o  output  2  00 load misalign, 01 store misalign, 10 bus timeout
- bad_addr_o  output  32  faulting req_addr, valid with exc_o
- mem_address  output  32  {req_addr[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_byte_en  output  4  active-high byte lanes (bit i = bits 8i+7:8i)
- mem_rd  output  1  read strobe
- mem_wr  output  1  write strobe
- mem_rdata  input  32  memory read word
- mem_ready  input  1  memory acknowledge, sampled each cycle in ACCESS

Behaviour:
- Reset (rst_n=0 at rising edge): state IDLE; all outputs 0; timeout counter 0. Reset mid-ACCESS drops the strobes in the next cycle and discards the access.
- States: IDLE, ACCESS.
- Accept condition: state IDLE, req_valid=1, done_o=0, exc_o=0. The done/exc guard blocks re-accepting the request the pipeline is retiring that cycle.
- On accept, alignment check:
  - half requires addr[0]=0; word requires addr[1:0]=0; byte is always aligned.
  - Misaligned: next cycle exc_o=1, exc_code_o per req_we, bad_addr_o=req_addr; stay IDLE; no strobe ever asserted.
  - Aligned: register address, size, sign, we, lane data and byte enables; go to ACCESS.
- stall_o is combinational: 1 when state=ACCESS, or when the accept condition holds with an aligned request. It is 0 in the done_o and exc_o cycles.
- ACCESS:
  - mem_rd = ~we, mem_wr = we; mem_address, mem_wdata and mem_byte_en held constant.
  - The counter increments each cycle mem_ready=0.
  - mem_ready=1: capture mem_rdata; next cycle done_o=1, strobes 0, state IDLE.
  - Counter reaches TIMEOUT_CYCLES without ready: next cycle exc_o=1, exc_code_o=10, bad_addr_o=addr, strobes 0, IDLE.
  - mem_ready arriving in the same cycle the counter hits the limit counts as success.
- Minimum latency: accept at cycle 0, strobe in cycle 1, done_o in cycle 2 with zero wait states. Each wait state adds 1 cycle.
- Store lanes:
  - byte: wdata = {4{d[7:0]}}, byte_en = 0001 << addr[1:0]
  - half: wdata = {2{d[15:0]}}, byte_en = addr[1] ? 1100 : 0011
  - word: wdata = d, byte_en = 1111
- Loads: mem_byte_en = same lane pattern (informational).
- Load extract: shift the captured word right by 8*addr[1:0] for byte, 16*addr[1] for half. Then sign- or zero-extend from bit 7 or bit 15 per req_sign. Word loads pass through unchanged.
- load_data_o is 0 for stores and outside done_o cycles.
- done_o and exc_o are never both 1.

Test Plan:
- Byte store, addr 0x0000_0013, wdata 0x0000_00A5, mem_ready tied 1: mem_wr=1 in cycle 1 only, byte_en=1000, mem_wdata=0xA5A5_A5A5, mem_address=0x10; done_o in cycle 2; stall_o=1 in cycles 0-1.
- Signed byte load, addr 0x21, mem_rdata=0x1234_80FF: load_data_o=0xFFFF_FF80; same with req_sign=0 gives 0x0000_0080.
- Unsigned half load, addr 0x42, mem_rdata=0xBEEF_0000, mem_ready delayed 3 cycles: mem_rd held 4 cycles; done_o in cycle 5; load_data_o=0x0000_BEEF.
- Word store to 0x102: exc_o=1 in cycle 1, exc_code_o=01, bad_addr_o=0x102; mem_wr never asserted; stall_o=0 throughout.
- TIMEOUT_CYCLES=4, word load, mem_ready held 0: mem_rd high for 4 cycles, then exc_o=1 with exc_code_o=10 and strobes 0; a following request is accepted normally.
- rst_n=0 during the second wait cycle of a store: strobes 0 and all outputs 0 after the edge; no done_o or exc_o pulse; a new request after reset completes normally.
